// File: rtl/multicast_inject_fifo.sv
// Packet buffer for the multicast injector: circular storage, read/write pointers,
// occupancy counter and a registered ready flag (high when not full).
module multicast_inject_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // Pushes are gated by the registered ready flag, so a full buffer never overwrites.
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ready <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count_next;
            // Ready is computed from next occupancy so it never depends on i_valid combinationally.
            ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/linear_network_multicast_injector.sv
// Injects multicast packets into a linear network: buffers accepted packets, drops
// zero-mask packets, and issues one packet per cycle through a zeroed output register.
module linear_network_multicast_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data_bus,
    input  logic [NUM_NODE-1:0]   i_dest,
    input  logic                  i_hold,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data_bus,
    output logic [NUM_NODE-1:0]   o_cmd,
    output logic                  o_en,
    output logic [15:0]           o_issue_cnt,
    output logic [15:0]           o_drop_cnt
);
    localparam int CNT_W   = 16;
    localparam int ENTRY_W = DATA_WIDTH + NUM_NODE;

    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_ready;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   drop_cnt;

    assign accept = i_valid && o_ready;
    assign push   = accept && (i_dest != '0);
    assign drop   = accept && (i_dest == '0);
    assign pop    = !fifo_empty && !i_hold;

    assign o_ready     = fifo_ready;
    assign o_issue_cnt = issue_cnt;
    assign o_drop_cnt  = drop_cnt;

    multicast_inject_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({i_data_bus, i_dest}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .ready (fifo_ready)
    );

    // Idle cycles drive all-zero dummy data so the network never sees stale payloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_cmd      <= '0;
            o_en       <= 1'b0;
            issue_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            o_valid    <= pop;
            o_data_bus <= pop ? head[ENTRY_W-1 -: DATA_WIDTH] : '0;
            o_cmd      <= pop ? head[NUM_NODE-1:0] : '0;
            o_en       <= 1'b1;
            if (pop)  issue_cnt <= issue_cnt + 1'b1;
            if (drop) drop_cnt  <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_linear_network_multicast_injector.sv
// Self-checking bench for linear_network_multicast_injector: scenario tasks plus a
// negedge scoreboard monitor comparing issued packets against an expected queue.
module tb_linear_network_multicast_injector;
    localparam int DW = 32;
    localparam int NN = 4;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data_bus;
    logic [NN-1:0] i_dest;
    logic          i_hold;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic [NN-1:0] o_cmd;
    logic          o_en;
    logic [15:0]   o_issue_cnt;
    logic [15:0]   o_drop_cnt;

    logic [DW+NN-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int valid_seen = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    linear_network_multicast_injector #(
        .DATA_WIDTH (DW),
        .NUM_NODE   (NN),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_bus  (i_data_bus),
        .i_dest      (i_dest),
        .i_hold      (i_hold),
        .o_valid     (o_valid),
        .o_data_bus  (o_data_bus),
        .o_cmd       (o_cmd),
        .o_en        (o_en),
        .o_issue_cnt (o_issue_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    // Scoreboard: every issued packet must match the oldest expected one; idle cycles carry zeros.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (o_valid === 1'b1) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_issue: got data=%h cmd=%b, expected no packet", o_data_bus, o_cmd);
                end else begin
                    logic [DW+NN-1:0] e;
                    e = exp_q.pop_front();
                    if ({o_data_bus, o_cmd} !== e) begin
                        fails++;
                        $display("FAIL issue_data: got data=%h cmd=%b, expected data=%h cmd=%b",
                                 o_data_bus, o_cmd, e[DW+NN-1:NN], e[NN-1:0]);
                    end
                end
            end else if (o_valid !== 1'b0 || o_data_bus !== '0 || o_cmd !== '0) begin
                fails++;
                $display("FAIL idle_zero: got valid=%b data=%h cmd=%b, expected 0/0/0", o_valid, o_data_bus, o_cmd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NN-1:0] m, output logic acc);
        @(negedge clk);
        i_valid    = v;
        i_data_bus = d;
        i_dest     = m;
        acc = v && (o_ready === 1'b1);
        if (acc && m != '0) exp_q.push_back({d, m});
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 200) begin
            @(negedge clk);
            i_valid = 1'b0;
            b++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d packets still pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (o_valid !== 1'b0 || o_data_bus !== '0 || o_cmd !== '0 || o_en !== 1'b0 ||
            o_issue_cnt !== 16'd0 || o_drop_cnt !== 16'd0 || o_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h cmd=%b en=%b iss=%0d drp=%0d rdy=%b, expected all 0",
                     o_valid, o_data_bus, o_cmd, o_en, o_issue_cnt, o_drop_cnt, o_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (o_ready !== 1'b1 || o_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: ready=%b en=%b, expected 1/1", o_ready, o_en);
        end
    endtask

    task automatic test_single();
        logic acc;
        drive(1'b1, 32'hDEADBEEF, 4'b1010, acc);
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL single_accept: ready=%b, expected 1", acc); end
        @(negedge clk);
        i_valid = 1'b0;
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL single_early: valid=%b, expected 0", o_valid); end
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_cmd !== 4'b1010 || o_data_bus !== 32'hDEADBEEF || o_issue_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_issue: valid=%b cmd=%b data=%h iss=%0d, expected 1/1010/deadbeef/1",
                     o_valid, o_cmd, o_data_bus, o_issue_cnt);
        end
        drain();
    endtask

    task automatic test_zero_mask();
        logic acc;
        int vs0;
        vs0 = valid_seen;
        drive(1'b1, 32'h1, 4'b0000, acc);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (o_drop_cnt !== 16'd1 || dut.u_fifo.count !== 4'd0 || valid_seen != vs0) begin
            fails++;
            $display("FAIL zero_mask: drop=%0d occ=%0d issues=%0d, expected 1/0/0",
                     o_drop_cnt, dut.u_fifo.count, valid_seen - vs0);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        i_hold = 1'b1;
        for (int i = 0; i < FD; i++) begin
            drive(1'b1, 32'h1000 + i, NN'((i % 15) + 1), acc);
            tests++;
            if (acc !== 1'b1) begin fails++; $display("FAIL fill_accept[%0d]: ready=%b, expected 1", i, acc); end
        end
        drive(1'b1, 32'h9999, 4'b0001, acc);
        tests++;
        if (o_ready !== 1'b0 || dut.u_fifo.count !== 4'd8) begin
            fails++;
            $display("FAIL fill_full: ready=%b occ=%0d, expected 0/8", o_ready, dut.u_fifo.count);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_hold  = 1'b0;
        for (int i = 0; i < FD; i++) begin
            @(negedge clk);
            tests++;
            if (o_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: valid=%b, expected 1", i, o_valid); end
            if (i == 0) begin
                tests++;
                if (o_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_after_pop: ready=%b, expected 1", o_ready); end
            end
        end
        drain();
    endtask

    task automatic test_streaming();
        logic acc;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'hA000 + i, NN'($urandom_range(1, 15)), acc);
            tests++;
            if (acc !== 1'b1) begin fails++; $display("FAIL stream_accept[%0d]: ready=%b, expected 1", i, acc); end
            if (i >= 1) begin
                tests++;
                if (dut.u_fifo.count > 4'd1) begin
                    fails++; $display("FAIL stream_occ[%0d]: occ=%0d, expected <=1", i, dut.u_fifo.count);
                end
            end
            if (i >= 2) begin
                tests++;
                if (o_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: valid=%b, expected 1", i, o_valid); end
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
            tests++;
            if (o_valid !== 1'b1) begin fails++; $display("FAIL stream_tail[%0d]: valid=%b, expected 1", i, o_valid); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic acc;
        int vs0;
        i_hold = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hB000 + i, 4'b0110, acc);
        @(negedge clk);
        i_valid = 1'b0;
        i_hold  = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        i_hold = 1'b1;
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0 || o_data_bus !== '0 || o_cmd !== '0 || o_en !== 1'b0 || o_issue_cnt !== 16'd0 ||
            o_drop_cnt !== 16'd0 || o_ready !== 1'b0 || dut.u_fifo.count !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b data=%h cmd=%b en=%b iss=%0d drp=%0d rdy=%b occ=%0d, expected all 0",
                     o_valid, o_data_bus, o_cmd, o_en, o_issue_cnt, o_drop_cnt, o_ready, dut.u_fifo.count);
        end
        exp_q.delete();
        vs0 = valid_seen;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (o_ready !== 1'b1 || o_en !== 1'b1) begin
            fails++; $display("FAIL mid_reset_release: ready=%b en=%b, expected 1/1", o_ready, o_en);
        end
        i_hold = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (valid_seen != vs0 || dut.u_fifo.count !== 4'd0) begin
            fails++; $display("FAIL mid_reset_stale: issues=%0d occ=%0d, expected 0/0", valid_seen - vs0, dut.u_fifo.count);
        end
    endtask

    task automatic test_counter_wrap();
        logic acc;
        int missed = 0;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, DW'(i), NN'((i % 15) + 1), acc);
            if (acc !== 1'b1) missed++;
        end
        tests++;
        if (missed != 0) begin fails++; $display("FAIL wrap_accept: %0d rejected, expected 0", missed); end
        drain();
        tests++;
        if (o_issue_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_ffff: iss=%h, expected ffff", o_issue_cnt); end
        drive(1'b1, 32'hC0FFEE, 4'b1111, acc);
        drain();
        tests++;
        if (o_issue_cnt !== 16'h0000 || o_drop_cnt !== 16'h0000) begin
            fails++; $display("FAIL wrap_zero: iss=%h drp=%h, expected 0000/0000", o_issue_cnt, o_drop_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_data_bus = '0;
        i_dest     = '0;
        i_hold     = 1'b0;
        test_reset();
        mon_en = 1'b1;
        test_single();
        test_zero_mask();
        test_back_to_back();
        test_streaming();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
